// File: rtl/apb_lsu.sv
// APB master load/store unit: takes one request at a time, aligns it onto the
// bus, runs SETUP/ACCESS, and returns extended load data with status flags.
module apb_lsu #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    APB_PCLK,
  input  logic                    APB_PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_misalign,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   APB_paddr,
  output logic [DATA_WIDTH-1:0]   APB_pdata,
  input  logic [DATA_WIDTH-1:0]   APB_prdata,
  output logic                    APB_psel,
  output logic                    APB_penable,
  output logic                    APB_pwrite,
  output logic [DATA_WIDTH/8-1:0] APB_pstb,
  input  logic                    APB_pready,
  input  logic                    APB_perr
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned OW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic                  signed_q, signed_d;
  logic [1:0]            size_q, size_d;
  logic [OW-1:0]         off_q, off_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic [NB-1:0]         pstb_q, pstb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  misalign_q, misalign_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           cnt_q, cnt_d;

  logic                  size_illegal;
  logic                  addr_misalign;
  logic [NB-1:0]         wr_strb;
  logic [DATA_WIDTH-1:0] wr_data;

  // Decode the incoming request: legality, alignment, lane placement.
  always_comb begin
    size_illegal = (req_size == 2'd3) && (DATA_WIDTH == 32);
    case (req_size)
      2'd0:    addr_misalign = 1'b0;
      2'd1:    addr_misalign = req_addr[0];
      2'd2:    addr_misalign = |req_addr[1:0];
      default: addr_misalign = |req_addr[2:0];
    endcase
    wr_data = req_wdata << {req_addr[OW-1:0], 3'b000};
    for (int i = 0; i < int'(NB); i++) begin
      wr_strb[i] = (i >= int'(req_addr[OW-1:0])) &&
                   (i < int'(req_addr[OW-1:0]) + (1 << req_size));
    end
  end

  // Next-state logic for the transfer FSM and the captured request/response.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    signed_d   = signed_q;
    size_d     = size_q;
    off_d      = off_q;
    paddr_d    = paddr_q;
    pdata_d    = pdata_q;
    pstb_d     = pstb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d    = req_write;
          signed_d   = req_signed;
          size_d     = req_size;
          off_d      = req_addr[OW-1:0];
          rdata_d    = '0;
          err_d      = 1'b0;
          misalign_d = 1'b0;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          if (size_illegal) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (addr_misalign) begin
            misalign_d = 1'b1;
            state_d    = StResp;
          end else begin
            // Bus-facing fields only change for transfers that reach the bus.
            paddr_d = {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            pdata_d = wr_data;
            pstb_d  = req_write ? wr_strb : '1;
            state_d = StSetup;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (APB_pready) begin
          rdata_d = APB_prdata;
          err_d   = APB_perr;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((TIMEOUT != 0) && (cnt_d == TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge APB_PCLK) begin
    if (!APB_PRESETn) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= 2'd0;
      off_q      <= '0;
      paddr_q    <= '0;
      pdata_q    <= '0;
      pstb_q     <= '1;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      signed_q   <= signed_d;
      size_q     <= size_d;
      off_q      <= off_d;
      paddr_q    <= paddr_d;
      pdata_q    <= pdata_d;
      pstb_q     <= pstb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  logic [DATA_WIDTH-1:0] lane;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic                  lane_sign;

  // Extract the addressed lane and extend it; zero unless a clean load.
  always_comb begin
    lane = rdata_q >> {off_q, 3'b000};
    case (size_q)
      2'd0: begin
        lane_mask = DATA_WIDTH'(64'hFF);
        lane_sign = lane[7];
      end
      2'd1: begin
        lane_mask = DATA_WIDTH'(64'hFFFF);
        lane_sign = lane[15];
      end
      2'd2: begin
        lane_mask = DATA_WIDTH'(64'hFFFF_FFFF);
        lane_sign = lane[31];
      end
      default: begin
        lane_mask = '1;
        lane_sign = 1'b0;
      end
    endcase
    rsp_rdata = '0;
    if ((state_q == StResp) && !write_q && !err_q && !misalign_q && !timeout_q) begin
      rsp_rdata = (lane & lane_mask) | ((signed_q && lane_sign) ? ~lane_mask : '0);
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_err      = rsp_valid & err_q;
  assign rsp_misalign = rsp_valid & misalign_q;
  assign rsp_timeout  = rsp_valid & timeout_q;
  assign APB_psel     = (state_q == StSetup) || (state_q == StAccess);
  assign APB_penable  = (state_q == StAccess);
  assign APB_pwrite   = APB_psel & write_q;
  assign APB_paddr    = paddr_q;
  assign APB_pdata    = pdata_q;
  assign APB_pstb     = pstb_q;

endmodule

// File: tb/tb_apb_lsu.sv
// Bench for apb_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (TIMEOUT=16) driven with directed and random requests against a timeline model.
module tb_apb_lsu;

  localparam int T0 = 4;
  localparam int T1 = 16;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-driven inputs, one slot per instance.
  logic        req_valid [2];
  logic        req_write [2];
  logic        req_signed[2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [63:0] prdata    [2];
  logic        pready    [2];
  logic        perr      [2];

  logic        ready0, rv0, err0, mis0, to0, psel0, pen0, pw0;
  logic [31:0] rdata0, paddr0, pdata0;
  logic [3:0]  pstb0;
  logic        ready1, rv1, err1, mis1, to1, psel1, pen1, pw1;
  logic [63:0] rdata1, pdata1;
  logic [31:0] paddr1;
  logic [7:0]  pstb1;

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(T0)) u_dut32 (
    .APB_PCLK(clk), .APB_PRESETn(rstn),
    .req_valid(req_valid[0]), .req_ready(ready0), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0][31:0]),
    .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0), .rsp_misalign(mis0),
    .rsp_timeout(to0),
    .APB_paddr(paddr0), .APB_pdata(pdata0), .APB_prdata(prdata[0][31:0]),
    .APB_psel(psel0), .APB_penable(pen0), .APB_pwrite(pw0), .APB_pstb(pstb0),
    .APB_pready(pready[0]), .APB_perr(perr[0])
  );

  apb_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(T1)) u_dut64 (
    .APB_PCLK(clk), .APB_PRESETn(rstn),
    .req_valid(req_valid[1]), .req_ready(ready1), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]),
    .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1), .rsp_misalign(mis1),
    .rsp_timeout(to1),
    .APB_paddr(paddr1), .APB_pdata(pdata1), .APB_prdata(prdata[1]),
    .APB_psel(psel1), .APB_penable(pen1), .APB_pwrite(pw1), .APB_pstb(pstb1),
    .APB_pready(pready[1]), .APB_perr(perr[1])
  );

  logic        o_ready[2], o_rv[2], o_err[2], o_mis[2], o_to[2];
  logic        o_psel[2], o_pen[2], o_pw[2];
  logic [63:0] o_rdata[2], o_pdata[2];
  logic [31:0] o_paddr[2];
  logic [7:0]  o_pstb[2];

  always_comb begin
    o_ready[0] = ready0; o_rv[0] = rv0; o_err[0] = err0; o_mis[0] = mis0; o_to[0] = to0;
    o_psel[0] = psel0; o_pen[0] = pen0; o_pw[0] = pw0;
    o_rdata[0] = {32'b0, rdata0}; o_pdata[0] = {32'b0, pdata0};
    o_paddr[0] = paddr0; o_pstb[0] = {4'b0, pstb0};
    o_ready[1] = ready1; o_rv[1] = rv1; o_err[1] = err1; o_mis[1] = mis1; o_to[1] = to1;
    o_psel[1] = psel1; o_pen[1] = pen1; o_pw[1] = pw1;
    o_rdata[1] = rdata1; o_pdata[1] = pdata1;
    o_paddr[1] = paddr1; o_pstb[1] = pstb1;
  end

  // Model state: the cycle timeline of the current transfer and its expected results.
  int          e_n[2], e_acc_last[2], e_resp[2], e_busy[2], rdy_cyc[2];
  logic [63:0] e_paddr[2], e_pdata[2], e_pstb[2], e_rdata[2];
  logic        e_pw[2], e_err[2], e_mis[2], e_to[2];
  logic [63:0] s_prdata[2];
  logic        s_perr[2];

  task automatic chk(input string name, input int u, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h want %h", name, u, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] dw_mask(input int u);
    return (u == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_rdata(input int u, input logic [1:0] sz, input logic sg,
                                          input logic [31:0] addr, input logic [63:0] prd);
    int          nb   = (u == 1) ? 8 : 4;
    int          off  = int'(addr % nb);
    int          bits = 8 << sz;
    logic [63:0] mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
    logic [63:0] v    = (prd & dw_mask(u)) >> (8 * off);
    v = v & mask;
    if (sg && v[bits-1]) v = v | ~mask;
    return v & dw_mask(u);
  endfunction

  function automatic logic [63:0] m_pdata(input int u, input logic [31:0] addr,
                                          input logic [63:0] wd);
    int nb = (u == 1) ? 8 : 4;
    return (wd << (8 * (addr % nb))) & dw_mask(u);
  endfunction

  function automatic logic [63:0] m_pstb(input int u, input logic wr, input logic [1:0] sz,
                                         input logic [31:0] addr);
    int          nb = (u == 1) ? 8 : 4;
    logic [63:0] all = (u == 1) ? 64'hFF : 64'hF;
    if (!wr) return all;
    return (((64'd1 << (1 << sz)) - 64'd1) << (addr % nb)) & all;
  endfunction

  // Slave: pready rises only on the planned cycle; junk data otherwise.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      pready[u] = (cyc == rdy_cyc[u]);
      prdata[u] = pready[u] ? s_prdata[u] : {$urandom, $urandom};
      perr[u]   = pready[u] ? s_perr[u] : 1'($urandom);
    end
  end

  logic x_busy, x_sel, x_en, x_rv;

  // Compare every cycle against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        x_busy = (cyc > e_n[u]) && (cyc <= e_busy[u]);
        x_sel  = (cyc >= e_n[u] + 1) && (cyc <= e_acc_last[u]);
        x_en   = (cyc >= e_n[u] + 2) && (cyc <= e_acc_last[u]);
        x_rv   = (cyc == e_resp[u]);
        chk("req_ready", u, 64'(o_ready[u]), 64'(!x_busy));
        chk("psel", u, 64'(o_psel[u]), 64'(x_sel));
        chk("penable", u, 64'(o_pen[u]), 64'(x_en));
        chk("rsp_valid", u, 64'(o_rv[u]), 64'(x_rv));
        if (x_sel) begin
          chk("paddr", u, 64'(o_paddr[u]), e_paddr[u]);
          chk("pdata", u, o_pdata[u], e_pdata[u]);
          chk("pstb", u, 64'(o_pstb[u]), e_pstb[u]);
          chk("pwrite", u, 64'(o_pw[u]), 64'(e_pw[u]));
        end
        if (x_rv) begin
          chk("rsp_rdata", u, o_rdata[u], e_rdata[u]);
          chk("rsp_err", u, 64'(o_err[u]), 64'(e_err[u]));
          chk("rsp_misalign", u, 64'(o_mis[u]), 64'(e_mis[u]));
          chk("rsp_timeout", u, 64'(o_to[u]), 64'(e_to[u]));
        end
      end
    end
  end

  // Issue one request in the current (idle) cycle; optionally reset mid-transfer.
  task automatic issue(input int u, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [63:0] wd, input int waits,
                       input logic [63:0] prd, input logic pe, input int abort_at,
                       output int lat);
    int   t  = (u == 1) ? T1 : T0;
    int   nb = (u == 1) ? 8 : 4;
    int   n;
    logic ill, mis, tout;
    n    = cyc;
    ill  = (sz == 2'd3) && (nb == 4);
    mis  = !ill && ((addr % (32'd1 << sz)) != 0);
    tout = !ill && !mis && (t > 0) && (waits >= t);
    e_n[u] = n;
    if (ill || mis) begin
      e_acc_last[u] = -100; e_resp[u] = n + 1; rdy_cyc[u] = -100;
    end else if (tout) begin
      e_acc_last[u] = n + 1 + t; e_resp[u] = n + 2 + t; rdy_cyc[u] = -100;
    end else begin
      e_acc_last[u] = n + 2 + waits; e_resp[u] = n + 3 + waits; rdy_cyc[u] = n + 2 + waits;
    end
    e_busy[u]  = e_resp[u];
    e_paddr[u] = 64'(addr - (addr % nb));
    e_pdata[u] = m_pdata(u, addr, wd);
    e_pstb[u]  = m_pstb(u, wr, sz, addr);
    e_pw[u]    = wr;
    e_err[u]   = ill || (!mis && !tout && pe);
    e_mis[u]   = mis;
    e_to[u]    = tout;
    e_rdata[u] = (wr || e_err[u] || mis || tout) ? 64'd0 : m_rdata(u, sz, sg, addr, prd);
    s_prdata[u] = prd;
    s_perr[u]   = pe;
    lat = e_resp[u] - n;
    req_valid[u] = 1'b1; req_write[u] = wr; req_size[u] = sz; req_signed[u] = sg;
    req_addr[u] = addr; req_wdata[u] = wd;
    @(posedge clk); #1;
    while (cyc <= e_busy[u]) begin
      if (abort_at > 0 && cyc == n + abort_at) begin
        rstn = 1'b0;
        e_acc_last[u] = cyc; e_resp[u] = -100; e_busy[u] = cyc; rdy_cyc[u] = -100;
      end
      // Requests offered while busy must be ignored.
      req_valid[u] = 1'($urandom); req_write[u] = 1'($urandom);
      req_size[u] = 2'($urandom); req_signed[u] = 1'($urandom);
      req_addr[u] = $urandom; req_wdata[u] = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    req_valid[u] = 1'b0;
    if (!rstn) begin
      repeat (2) begin @(posedge clk); #1; end
      rstn = 1'b1;
    end
  endtask

  initial begin
    int          lat;
    int          u, waits;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_size[i] = 2'd0; req_signed[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; prdata[i] = '0; pready[i] = 1'b0; perr[i] = 1'b0;
      e_n[i] = -100; e_acc_last[i] = -100; e_resp[i] = -100; e_busy[i] = -100;
      rdy_cyc[i] = -100; s_prdata[i] = '0; s_perr[i] = 1'b0;
      e_paddr[i] = '0; e_pdata[i] = '0; e_pstb[i] = '0; e_rdata[i] = '0;
      e_pw[i] = 1'b0; e_err[i] = 1'b0; e_mis[i] = 1'b0; e_to[i] = 1'b0;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    // Reset values of the bus-side registers.
    chk("rst_pstb", 0, 64'(o_pstb[0]), 64'hF);
    chk("rst_pstb", 1, 64'(o_pstb[1]), 64'hFF);
    chk("rst_paddr", 0, 64'(o_paddr[0]), 64'h0);
    chk("rst_pdata", 1, o_pdata[1], 64'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Hand-computed values pinning the model.
    chk("pin1_rdata", 0, m_rdata(0, 2'd0, 1'b1, 32'h1003, 64'h80AA_BBCC), 64'hFFFF_FF80);
    chk("pin1_pstb", 0, m_pstb(0, 1'b0, 2'd0, 32'h1003), 64'hF);
    chk("pin2_pdata", 0, m_pdata(0, 32'h2002, 64'h1234), 64'h1234_0000);
    chk("pin2_pstb", 0, m_pstb(0, 1'b1, 2'd1, 32'h2002), 64'hC);
    chk("pin3_lo", 1, m_rdata(1, 2'd2, 1'b0, 32'h10, 64'hDEAD_BEEF_0000_0001), 64'h1);
    chk("pin3_hi", 1, m_rdata(1, 2'd2, 1'b0, 32'h14, 64'hDEAD_BEEF_0000_0001),
        64'hDEAD_BEEF);
    chk("pin_half_sx", 1, m_rdata(1, 2'd1, 1'b1, 32'h6, 64'h8001_0000_0000_0000),
        64'hFFFF_FFFF_FFFF_8001);

    // Directed scenarios.
    issue(0, 1'b0, 2'd0, 1'b1, 32'h1003, 64'h0, 0, 64'h80AA_BBCC, 1'b0, 0, lat);
    chk("t1_latency", 0, 64'(lat), 64'd3);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h2002, 64'h1234, 0, 64'h0, 1'b0, 0, lat);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 64'h0, 3, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, lat);
    chk("t3_latency", 1, 64'(lat), 64'd6);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h14, 64'h0, 0, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, lat);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h1001, 64'h0, 0, 64'h0, 1'b0, 0, lat);
    chk("t4_latency", 0, 64'(lat), 64'd1);
    issue(0, 1'b0, 2'd3, 1'b0, 32'h1000, 64'h0, 0, 64'h0, 1'b0, 0, lat);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h40, 64'h0, 6, 64'h1111_2222, 1'b0, 0, lat);
    chk("t5_latency", 0, 64'(lat), 64'd6);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h40, 64'h0, 1, 64'h3333_4444, 1'b1, 0, lat);
    issue(1, 1'b0, 2'd3, 1'b1, 32'h8, 64'h0, 10, 64'h5555_6666_7777_8888, 1'b0, 3, lat);
    issue(1, 1'b1, 2'd3, 1'b0, 32'h18, 64'hA5A5_5A5A_0F0F_F0F0, 2, 64'h0, 1'b0, 0, lat);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      u     = int'($urandom_range(0, 1));
      sz    = 2'($urandom);
      a     = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      waits = int'($urandom_range(0, (u == 1) ? 5 : 6));
      issue(u, 1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, waits,
            {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 0, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
